// File: rtl/adder.sv
// ============================================================================
//  Module      : adder
//  Description : Two-operand WIDTH-bit adder for the processor datapath.
//                The sum on res is purely combinational and comes from a
//                carry-lookahead chain of 4-bit CLA groups. The same chain
//                also feeds a registered status stage, which captures the
//                sum together with carry, signed-overflow and zero flags.
//                Define ADDER_OVF_CNT_EN to add a 16-bit saturating counter
//                of carry-out events and its ovf_cnt port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder #(
    parameter int WIDTH = 32            // multiple of 4, minimum 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    output logic [WIDTH-1:0]   res,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   res_q,
    output logic               cout_q,
    output logic               ovf_q,
    output logic               zero_q,
`ifdef ADDER_OVF_CNT_EN
    output logic [15:0]        ovf_cnt,
`endif
    output logic               out_valid
);

    localparam int c_NGRP = WIDTH / 4;
    localparam int c_MSB  = WIDTH - 1;

    // Per-bit generate/propagate terms and the carry into each bit.
    logic [WIDTH-1:0]  w_g;
    logic [WIDTH-1:0]  w_p;
    logic [WIDTH-1:0]  w_c;
    logic [WIDTH-1:0]  w_sum;

    // Group-level terms. w_gc[k] is the carry into group k.
    // w_gc[c_NGRP] is the carry out of the whole adder.
    logic [c_NGRP-1:0] w_grp_g;
    logic [c_NGRP-1:0] w_grp_p;
    logic [c_NGRP:0]   w_gc;

    logic              w_cout;
    logic              w_ovf;
    logic              w_zero;

    // The adder has no carry-in, so the chain starts from zero.
    assign w_gc[0] = 1'b0;

    // Bit-level generate and propagate terms.
    assign w_g = op1 & op2;
    assign w_p = op1 ^ op2;

    generate
        for (genvar k = 0; k < c_NGRP; k++) begin : g_cla_grp
            localparam int B = 4 * k;

            // Carries inside the group are computed directly from the
            // carry into the group, not rippled bit by bit.
            assign w_c[B+0] = w_gc[k];
            assign w_c[B+1] = w_g[B+0]
                            | (w_p[B+0] & w_gc[k]);
            assign w_c[B+2] = w_g[B+1]
                            | (w_p[B+1] & w_g[B+0])
                            | (w_p[B+1] & w_p[B+0] & w_gc[k]);
            assign w_c[B+3] = w_g[B+2]
                            | (w_p[B+2] & w_g[B+1])
                            | (w_p[B+2] & w_p[B+1] & w_g[B+0])
                            | (w_p[B+2] & w_p[B+1] & w_p[B+0] & w_gc[k]);

            // Group generate and propagate terms.
            assign w_grp_g[k] = w_g[B+3]
                              | (w_p[B+3] & w_g[B+2])
                              | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                              | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B+0]);
            assign w_grp_p[k] = &w_p[B+3:B];

            // The carry between groups ripples from one group to the next.
            assign w_gc[k+1] = w_grp_g[k] | (w_grp_p[k] & w_gc[k]);
        end
    endgenerate

    assign w_sum  = w_p ^ w_c;
    assign w_cout = w_gc[c_NGRP];
    assign w_ovf  = (op1[c_MSB] == op2[c_MSB]) && (w_sum[c_MSB] != op1[c_MSB]);
    assign w_zero = (w_sum == '0);

    // The combinational output depends only on the operands.
    assign res = w_sum;

    // Status capture stage. Reset has priority, so a capture requested in
    // the same cycle as reset is dropped. Without in_valid, the data and
    // flags hold their previous values.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            res_q     <= w_sum;
            cout_q    <= w_cout;
            ovf_q     <= w_ovf;
            zero_q    <= w_zero;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef ADDER_OVF_CNT_EN
    logic [15:0] r_ovf_cnt;

    // Count captures that produce a carry out. The counter stops at all-ones
    // instead of wrapping back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_cnt <= 16'h0000;
        end else if (in_valid && w_cout && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'h0001;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder.sv
// ============================================================================
//  Module      : tb_adder
//  Description : Self-checking bench for adder (WIDTH = 32). A reference
//                model pushes the expected captures into a queue when the
//                stimulus is driven. The entries are popped and compared
//                when the registered stage presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder;

    localparam int c_W = 32;

    typedef struct {
        logic [c_W-1:0] sum;
        logic           cout;
        logic           ovf;
        logic           zero;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [c_W-1:0] op1;
    logic [c_W-1:0] op2;
    logic [c_W-1:0] res;
    logic           in_valid;
    logic [c_W-1:0] res_q;
    logic           cout_q;
    logic           ovf_q;
    logic           zero_q;
    logic           out_valid;
`ifdef ADDER_OVF_CNT_EN
    logic [15:0]    ovf_cnt;
    logic [15:0]    m_cnt = 16'h0000;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t m_last;

    adder #(.WIDTH(c_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .op1       (op1),
        .op2       (op2),
        .res       (res),
        .in_valid  (in_valid),
        .res_q     (res_q),
        .cout_q    (cout_q),
        .ovf_q     (ovf_q),
        .zero_q    (zero_q),
`ifdef ADDER_OVF_CNT_EN
        .ovf_cnt   (ovf_cnt),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference model: a 33-bit add supplies both the sum and the carry.
    function automatic exp_t model(input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        exp_t       e;
        logic [c_W:0] s;
        s      = {1'b0, a} + {1'b0, b};
        e.sum  = s[c_W-1:0];
        e.cout = s[c_W];
        e.ovf  = (a[c_W-1] == b[c_W-1]) && (s[c_W-1] != a[c_W-1]);
        e.zero = (s[c_W-1:0] == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle. The bench drives on the falling edge, checks the
    // combinational sum 1 time unit later, and then checks the registered
    // stage 1 time unit after the rising edge.
    task automatic cycle(input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                         input logic v, input logic r);
        exp_t e;
        exp_t p;
        @(negedge clk);
        op1 = a; op2 = b; in_valid = v; rst = r;
        #1;
        e = model(a, b);
        check("res_comb", {32'h0, res}, {32'h0, e.sum});
        if (v && !r) sb.push_back(e);
`ifdef ADDER_OVF_CNT_EN
        if (r)                                  m_cnt = 16'h0000;
        else if (v && e.cout && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
`endif
        @(posedge clk);
        #1;
        if (r) begin
            check("rst_res_q",     {32'h0, res_q}, 64'h0);
            check("rst_cout_q",    {63'h0, cout_q}, 64'h0);
            check("rst_ovf_q",     {63'h0, ovf_q}, 64'h0);
            check("rst_zero_q",    {63'h0, zero_q}, 64'h0);
            check("rst_out_valid", {63'h0, out_valid}, 64'h0);
            m_last = '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
        end else if (v) begin
            check("out_valid", {63'h0, out_valid}, 64'h1);
            check("sb_depth", 64'(sb.size()), 64'h1);
            if (sb.size() > 0) begin
                p = sb.pop_front();
                check("res_q",  {32'h0, res_q}, {32'h0, p.sum});
                check("cout_q", {63'h0, cout_q}, {63'h0, p.cout});
                check("ovf_q",  {63'h0, ovf_q}, {63'h0, p.ovf});
                check("zero_q", {63'h0, zero_q}, {63'h0, p.zero});
                m_last = p;
            end
        end else begin
            check("idle_out_valid", {63'h0, out_valid}, 64'h0);
            check("hold_res_q",     {32'h0, res_q}, {32'h0, m_last.sum});
            check("hold_cout_q",    {63'h0, cout_q}, {63'h0, m_last.cout});
            check("hold_ovf_q",     {63'h0, ovf_q}, {63'h0, m_last.ovf});
            check("hold_zero_q",    {63'h0, zero_q}, {63'h0, m_last.zero});
        end
`ifdef ADDER_OVF_CNT_EN
        check("ovf_cnt", {48'h0, ovf_cnt}, {48'h0, m_cnt});
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op1 = '0; op2 = '0;
        m_last = '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};

        // Reset, then let the stage sit idle.
        cycle(32'h0, 32'h0, 1'b0, 1'b1);
        cycle(32'h0, 32'h0, 1'b0, 1'b1);
        cycle(32'h0, 32'h0, 1'b0, 1'b0);

        // Basic sums, each a single capture pulse followed by an idle cycle.
        cycle(32'd15, 32'd10, 1'b1, 1'b0);
        cycle(32'd15, 32'd10, 1'b0, 1'b0);
        cycle(32'd5, 32'd123456789, 1'b1, 1'b0);
        cycle(32'd123456789, 32'd987654321, 1'b1, 1'b0);

        // Wrap-around, signed overflow, and both at once.
        cycle(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0);
        cycle(32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0);
        cycle(32'h80000000, 32'h80000000, 1'b1, 1'b0);
        cycle(32'h0, 32'h0, 1'b0, 1'b0);

        // Reset and capture in the same cycle: reset wins, and res still shows the sum.
        cycle(32'h12345678, 32'h11111111, 1'b1, 1'b1);
        cycle(32'h12345678, 32'h11111111, 1'b0, 1'b0);

        // Three back-to-back captures with changing operands, then idle.
        cycle(32'h00000010, 32'h00000020, 1'b1, 1'b0);
        cycle(32'hFFFFFFF0, 32'h00000010, 1'b1, 1'b0);
        cycle(32'hDEADBEEF, 32'h01010101, 1'b1, 1'b0);
        cycle(32'h0BADF00D, 32'h00000001, 1'b0, 1'b0);
        cycle(32'h0BADF00D, 32'h00000001, 1'b0, 1'b0);

        // Random operands with a random capture strobe.
        for (int i = 0; i < 40; i++) begin
            cycle($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef ADDER_OVF_CNT_EN
        // Drive the carry-out counter to saturation and past it.
        for (int i = 0; i < 65540; i++) begin
            cycle(32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b0);
        end
        cycle(32'h1, 32'h1, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog: if the bench stalls, report a failure and stop.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/adder.md
Name: adder

Overview:
- Parameterised two-operand unsigned/two's-complement adder for the processor datapath, used for PC increment and branch-target computation.
- Primary sum output `res` is purely combinational, with zero latency.
- A registered status stage on the single clock provides a captured sum plus carry, overflow and zero flags with a valid strobe, for consumers that need them timed to the clock.

Parameters:
- WIDTH, 32, operand and result width in bits; legal values are multiples of 4, minimum 4.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-high reset.
- op1  input  WIDTH  first operand.
- op2  input  WIDTH  second operand.
- res  output  WIDTH  combinational sum, (op1 + op2) mod 2^WIDTH.
- in_valid  input  1  capture strobe for the registered stage.
- res_q  output  WIDTH  registered sum.
- cout_q  output  1  registered unsigned carry-out.
- ovf_q  output  1  registered signed overflow.
- zero_q  output  1  registered flag: sum equal to zero.
- out_valid  output  1  registered outputs hold a fresh capture.
- ovf_cnt  output  16  carry-out event counter; present only with ADDER_OVF_CNT_EN.

Behaviour:
- res = low WIDTH bits of op1 + op2, with no carry-in.
  - Wrap-around is silent: FFFFFFFF + 1 = 00000000.
  - res depends only on op1/op2; it is unaffected by clk, rst or in_valid.
- Adder structure:
  - Carry-lookahead built from 4-bit CLA groups (generate/propagate per bit, group G/P, rippled group carries).
  - No "+" operator on the full width.
  - One carry chain is shared by the combinational and registered paths.
- Flag definitions:
  - cout = carry out of bit WIDTH-1.
  - ovf = (op1[MSB] == op2[MSB]) && (sum[MSB] != op1[MSB]).
  - zero = (sum == 0).
- Registered stage, evaluated each rising clk edge, highest priority first:
  - rst = 1: res_q, cout_q, ovf_q, zero_q, out_valid all cleared to 0.
  - in_valid = 1: res_q <= sum, cout_q <= cout, ovf_q <= ovf, zero_q <= zero, out_valid <= 1.
  - in_valid = 0: out_valid <= 0; res_q and flags hold their previous values.
- Timing and reset rules:
  - Latency from in_valid to out_valid is one cycle. Back-to-back in_valid gives one result per cycle.
  - Reset asserted in the same cycle as in_valid: reset wins and the capture is dropped.
  - Reset does not affect the combinational res.
- No X propagation from the registered stage after the first reset edge.

Optional Feature:
- Macro: ADDER_OVF_CNT_EN.
- Defined:
  - Port ovf_cnt (16 bits) exists.
  - Increments by 1 on each rising edge where in_valid = 1 and cout = 1.
  - Saturates at FFFF; does not wrap.
  - Cleared to 0 by rst, with reset priority.
- Not defined:
  - Port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- op1=15, op2=10 → res=25 within 1 time unit with no clock edge; in_valid pulse → res_q=25, cout_q=0, ovf_q=0, zero_q=0, out_valid=1 one cycle later.
- op1=5, op2=123456789 → res=123456794; op1=123456789, op2=987654321 → res=1111111110.
- op1=FFFFFFFF, op2=1 → res=00000000; captured: cout_q=1, zero_q=1, ovf_q=0; with ADDER_OVF_CNT_EN, ovf_cnt increments 0→1.
- op1=7FFFFFFF, op2=00000001 → res=80000000; captured: ovf_q=1, cout_q=0. op1=80000000, op2=80000000 → res=0, ovf_q=1, cout_q=1, zero_q=1.
- rst=1 and in_valid=1 in the same cycle with nonzero operands → all registered outputs 0 next cycle, while res still shows the sum.
- in_valid held 3 cycles with operands changing each cycle → res_q tracks each sum one cycle later; drop in_valid → out_valid=0 and res_q holds the last value.
